// File: rtl/mem_access.sv
// Data-memory access stage: turns a load/store in the EX/MEM slot into one bus
// transaction, aligns store data/byte mask, extracts and extends load data.
// Ports: i_clk/i_rst_n; pipeline slot in (i_valid, i_mem_read/write, i_funct3,
//   i_alu_result, i_rs2_data); bus out (o_dmem_req/addr/wen/mask/wdata) and in
//   (i_dmem_ready/rvalid/rdata); o_stall to upstream; completion o_done,
//   o_load_data, o_mem_byte_offset, o_bus_err, o_misalign.
// Latency: accept cycle + REQ cycles until ready (+ WAIT until rvalid) + 1 DONE.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to complete misaligned
//   halfword/word accesses locally with o_misalign=1 instead of issuing them.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_data,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_mem_byte_offset,
  output logic        o_bus_err,
  output logic        o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last counter value at which the access is still allowed to complete.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q, data_q, load_data_q;
  logic [2:0]  f3_q;
  logic        wr_q, bus_err_q;
  logic [7:0]  cnt_q;
  logic        start, trap, tmo;
  logic        fin_rd, fin_wr, fin_err;

  // funct3[1:0]: 00 byte, 01 halfword, 1x word (011/110/111 behave as LW).
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << {off[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic uns,
                                              input logic [1:0] off, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = off[1] ? r[31:16] : r[15:0];
    case (sz)
      2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = r;
    endcase
  endfunction

  // Reset gates the combinational stall so every output reads 0 while held.
  assign start = i_rst_n & i_valid & (i_mem_read | i_mem_write) & (state == IDLE);
  assign tmo   = (cnt_q == TMO_LAST);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = start & (((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                         (i_funct3[1] & (|i_alu_result[1:0])));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        misalign_q <= 1'b0;
    else if (trap)                       misalign_q <= 1'b1;
    else if (fin_rd | fin_wr | fin_err)  misalign_q <= 1'b0;
  end
  assign o_misalign = misalign_q;
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fin_rd    = 1'b0;
    fin_wr    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: begin
        if (trap)       state_nxt = DONE;
        else if (start) state_nxt = REQ;
      end
      REQ: begin
        if (i_dmem_ready) begin
          if (wr_q) begin
            fin_wr    = 1'b1;
            state_nxt = DONE;
          end else if (i_dmem_rvalid) begin
            fin_rd    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (tmo) begin
          fin_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid) begin
          fin_rd    = 1'b1;
          state_nxt = DONE;
        end else if (tmo) begin
          fin_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      f3_q        <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q <= i_alu_result;
        data_q <= i_rs2_data;
        f3_q   <= i_funct3;
        wr_q   <= i_mem_write;
        cnt_q  <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // Completion results persist until the next completion of any kind.
      if (fin_rd | fin_wr | fin_err | trap) begin
        load_data_q <= fin_rd ? load_extend(f3_q[1:0], f3_q[2], addr_q[1:0], i_dmem_rdata)
                              : 32'd0;
        bus_err_q   <= fin_err;
      end
    end
  end

  assign o_dmem_req        = (state == REQ);
  assign o_dmem_addr       = o_dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_dmem_wen        = o_dmem_req & wr_q;
  assign o_dmem_mask       = o_dmem_req ? lane_mask(f3_q[1:0], addr_q[1:0]) : 4'd0;
  assign o_dmem_wdata      = o_dmem_wen ? store_data(f3_q[1:0], data_q) : 32'd0;
  assign o_stall           = start | (state == REQ) | (state == WAIT);
  assign o_done            = (state == DONE);
  assign o_load_data       = load_data_q;
  assign o_mem_byte_offset = addr_q[1:0];
  assign o_bus_err         = bus_err_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles an access SHALL wait in REQ+WAIT before forced error completion (8-bit counter).
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 i_mem_read / i_mem_write  input  1 each  load / store decoded.
REQ-006 i_funct3  input  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores 000/001/010).
REQ-007 i_alu_result  input  32  effective byte address.
REQ-008 i_rs2_data  input  32  store data (after forwarding).
REQ-009 o_dmem_req  output  1  bus request; o_dmem_addr output 32 word-aligned address; o_dmem_wen output 1; o_dmem_mask output 4; o_dmem_wdata output 32.
REQ-010 i_dmem_ready  input  1  request accepted; i_dmem_rvalid  input  1  read data valid; i_dmem_rdata  input  32.
REQ-011 o_stall  output  1  freeze upstream stages and hold the EX/MEM slot.
REQ-012 o_done  output  1  one-cycle pulse, access complete; o_load_data output 32 extended load value; o_mem_byte_offset output 2; o_bus_err output 1; o_misalign output 1.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-014 IDLE: i_valid & (i_mem_read|i_mem_write) SHALL capture address, data, funct3, direction and go to REQ next cycle; o_stall SHALL be high combinationally that same cycle.
REQ-015 Non-memory or invalid slots SHALL cause no request, no stall, no o_done.
REQ-016 REQ: o_dmem_req high, outputs stable until i_dmem_ready sampled high; store -> DONE; load -> WAIT, or -> DONE if i_dmem_rvalid also high that cycle (rdata captured).
REQ-017 WAIT: i_dmem_rvalid high SHALL capture i_dmem_rdata and go to DONE; o_dmem_req low.
REQ-018 o_stall SHALL be high in REQ and WAIT and low in DONE; DONE lasts exactly one cycle, asserts o_done, then returns to IDLE (back-to-back access may start from IDLE the following cycle).
REQ-019 Timeout counter SHALL clear on entering REQ, increment each REQ/WAIT cycle; on reaching TIMEOUT_CYCLES go to DONE with o_bus_err=1 and o_load_data=0.
REQ-020 o_dmem_addr = {addr[31:2],2'b00}; o_mem_byte_offset = addr[1:0].
REQ-021 Store mask: SB 4'b0001<<off, SH 4'b0011<<{off[1],1'b0}, SW 4'b1111; wdata byte/halfword replicated across all lanes.
REQ-022 Load: select byte/halfword by offset, sign-extend (LB/LH) or zero-extend (LBU/LHU); funct3 011/110/111 SHALL be treated as LW.
REQ-023 Load mask SHALL equal the store mask for the same size.
REQ-024 o_load_data, o_bus_err, o_misalign SHALL hold their DONE value until the next DONE.

Reset
REQ-025 i_rst_n low SHALL immediately force state IDLE, counter 0, all outputs 0 (o_dmem_req drops asynchronously), abandoning any in-flight access; late i_dmem_rvalid after reset SHALL be ignored in IDLE.

Configuration
REQ-026 Macro MEM_ACCESS_MISALIGN_TRAP_EN defined: halfword access with off[0]=1 or word access with off!=0 SHALL issue no bus request and go IDLE->DONE with o_misalign=1, o_load_data=0 (stall one cycle).
REQ-027 Macro undefined: o_misalign tied 0; misaligned accesses issue normally using low address bits as given (halfword off 3 uses lanes 3:2, word ignores offset).

Verification
REQ-028 LB addr 0x103, rdata 0x80AABBCC, ready and rvalid same cycle -> o_load_data 0xFFFFFF80, o_dmem_addr 0x100, mask 0001<<3, o_done cycle 2.
REQ-029 SH addr 0x202, data 0x1234ABCD, ready after 3 cycles -> mask 1100, wdata 0xABCDABCD, o_stall high 4 cycles.
REQ-030 LHU, ready never asserted, TIMEOUT_CYCLES=4 -> DONE after 4 REQ cycles, o_bus_err=1, o_load_data 0.
REQ-031 LW in flight, i_rst_n pulsed low in WAIT -> o_dmem_req/o_stall 0 immediately, later rvalid ignored, no o_done.
REQ-032 With MEM_ACCESS_MISALIGN_TRAP_EN, LW addr 0x101 -> no o_dmem_req, o_misalign=1 with o_done; without macro -> request to 0x100, mask 1111.
